// File: rtl/fpu_add_sub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor.
// S1: unpack, classify, sort by magnitude, align the smaller significand.
// S2: add/subtract significands and normalize.
// S3: round to nearest even, pack, and raise flags {NV, OF, UF, NX}.
module fpu_add_sub_pipe #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [EXPW+FRACW:0]   opA,
  input  logic [EXPW+FRACW:0]   opB,
  input  logic                  sub,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [EXPW+FRACW:0]   result,
  output logic [3:0]            flags
);
  localparam int W   = 1 + EXPW + FRACW;
  localparam int SW  = FRACW + 4;          // hidden + frac + guard/round/sticky
  localparam int EW1 = EXPW + 1;           // one spare bit to see overflow
  localparam logic [EXPW-1:0]  EONES = {EXPW{1'b1}};
  localparam logic [FRACW-1:0] FZERO = '0;
  localparam logic [W-1:0]     QNAN  = {1'b0, EONES, 1'b1, {(FRACW-1){1'b0}}};

  // ---------------- handshake ----------------
  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  assign adv3    = !v3_q || outReady;
  assign adv2    = !v2_q || adv3;
  assign adv1    = !v1_q || adv2;
  assign inReady = adv1;

  // ---------------- S1: unpack / classify ----------------
  logic             sa, sb;
  logic [EXPW-1:0]  ea, eb;
  logic [FRACW-1:0] fa, fb;
  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan;

  assign sa = opA[W-1];
  assign ea = opA[W-2:FRACW];
  assign fa = opA[FRACW-1:0];
  assign sb = opB[W-1] ^ sub;             // effective sign of the second operand
  assign eb = opB[W-2:FRACW];
  assign fb = opB[FRACW-1:0];

  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign a_inf  = (&ea) && !(|fa);
  assign b_inf  = (&eb) && !(|fb);
  assign a_snan = a_nan && !fa[FRACW-1];
  assign b_snan = b_nan && !fb[FRACW-1];

  logic         s1_spec_d, s1_nv_d;
  logic [W-1:0] s1_sres_d;

  // Special-operand result: NaNs collapse to canonical NaN, infinities pass through.
  always_comb begin
    s1_spec_d = a_nan || b_nan || a_inf || b_inf;
    s1_nv_d   = 1'b0;
    s1_sres_d = QNAN;
    if (a_nan || b_nan)                s1_nv_d   = a_snan || b_snan;
    else if (a_inf && b_inf && sa != sb) s1_nv_d = 1'b1;
    else if (a_inf)                    s1_sres_d = {sa, EONES, FZERO};
    else if (b_inf)                    s1_sres_d = {sb, EONES, FZERO};
  end

  logic             swap;
  logic [EXPW-1:0]  el, es, el_eff, es_eff, diff;
  logic [FRACW-1:0] fl, fs;
  logic [FRACW:0]   sig_s_raw;
  logic [2*SW-1:0]  wide;
  logic [SW-1:0]    s1_sigl_d, s1_sigs_d;
  logic             s1_sl_d, s1_ss_d;

  // Sort by magnitude (ties keep opA as larger) and align the smaller operand.
  always_comb begin
    swap      = {eb, fb} > {ea, fa};
    el        = swap ? eb : ea;
    fl        = swap ? fb : fa;
    es        = swap ? ea : eb;
    fs        = swap ? fa : fb;
    s1_sl_d   = swap ? sb : sa;
    s1_ss_d   = swap ? sa : sb;
    el_eff    = (el == '0) ? EXPW'(1) : el;
    es_eff    = (es == '0) ? EXPW'(1) : es;
    diff      = el_eff - es_eff;
    sig_s_raw = {|es, fs};
    s1_sigl_d = {|el, fl, 3'b000};
    wide      = {sig_s_raw, 3'b000, {SW{1'b0}}} >> diff;
    if (32'(diff) >= SW - 1)
      s1_sigs_d = {{(SW-1){1'b0}}, |sig_s_raw};
    else
      s1_sigs_d = wide[2*SW-1:SW] | {{(SW-1){1'b0}}, |wide[SW-1:0]};
  end

  logic            s1_spec_q, s1_nv_q, s1_sl_q, s1_ss_q, s1_zs_q;
  logic [W-1:0]    s1_sres_q;
  logic [EXPW-1:0] s1_exp_q;
  logic [SW-1:0]   s1_sigl_q, s1_sigs_q;

  // S1 register: capture an accepted operand pair.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1_q      <= 1'b0;
      s1_spec_q <= 1'b0;
      s1_nv_q   <= 1'b0;
      s1_sres_q <= '0;
      s1_sl_q   <= 1'b0;
      s1_ss_q   <= 1'b0;
      s1_zs_q   <= 1'b0;
      s1_exp_q  <= '0;
      s1_sigl_q <= '0;
      s1_sigs_q <= '0;
    end else if (adv1) begin
      v1_q <= inValid;
      if (inValid) begin
        s1_spec_q <= s1_spec_d;
        s1_nv_q   <= s1_nv_d;
        s1_sres_q <= s1_sres_d;
        s1_sl_q   <= s1_sl_d;
        s1_ss_q   <= s1_ss_d;
        s1_zs_q   <= sa && sb;            // only (-0)+(-0) yields a negative exact zero
        s1_exp_q  <= el_eff;
        s1_sigl_q <= s1_sigl_d;
        s1_sigs_q <= s1_sigs_d;
      end
    end
  end

  // ---------------- S2: add / normalize ----------------
  logic [SW:0]    sum;
  logic [SW-1:0]  s2_norm_d;
  logic [EW1-1:0] s2_exp_d;
  int             lz, lim, sh;

  // Add, then normalize: right 1 on carry, else left by lzc but not below exp 1.
  always_comb begin
    sum = (s1_sl_q ^ s1_ss_q) ? ({1'b0, s1_sigl_q} - {1'b0, s1_sigs_q})
                              : ({1'b0, s1_sigl_q} + {1'b0, s1_sigs_q});
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (sum[i]) lz = SW - 1 - i;
    lim = int'(s1_exp_q) - 1;
    sh  = (lz < lim) ? lz : lim;
    if (sum[SW]) begin
      s2_norm_d = {sum[SW:2], sum[1] | sum[0]};
      s2_exp_d  = {1'b0, s1_exp_q} + EW1'(1);
    end else begin
      s2_norm_d = sum[SW-1:0] << sh;
      s2_exp_d  = EW1'(int'(s1_exp_q) - sh);
      if (!s2_norm_d[SW-1]) s2_exp_d = '0;  // shift was limited: subnormal
    end
  end

  logic           s2_spec_q, s2_nv_q, s2_sgn_q, s2_zs_q, s2_zero_q;
  logic [W-1:0]   s2_sres_q;
  logic [EW1-1:0] s2_exp_q;
  logic [SW-1:0]  s2_norm_q;

  // S2 register: normalized significand and exponent.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_q      <= 1'b0;
      s2_spec_q <= 1'b0;
      s2_nv_q   <= 1'b0;
      s2_sres_q <= '0;
      s2_sgn_q  <= 1'b0;
      s2_zs_q   <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_exp_q  <= '0;
      s2_norm_q <= '0;
    end else if (adv2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_spec_q <= s1_spec_q;
        s2_nv_q   <= s1_nv_q;
        s2_sres_q <= s1_sres_q;
        s2_sgn_q  <= s1_sl_q;
        s2_zs_q   <= s1_zs_q;
        s2_zero_q <= (sum == '0);
        s2_exp_q  <= s2_exp_d;
        s2_norm_q <= s2_norm_d;
      end
    end
  end

  // ---------------- S3: round / pack / flags ----------------
  logic [FRACW:0]   mant;
  logic [FRACW+1:0] mr;
  logic             g, r, s, inc, nx, of;
  logic [EW1-1:0]   ex;
  logic [FRACW-1:0] fo;
  logic [W-1:0]     s3_res_d;
  logic [3:0]       s3_flg_d;

  // Round to nearest even, handle carry/overflow, select special or zero result.
  always_comb begin
    mant = s2_norm_q[SW-1:3];
    g    = s2_norm_q[2];
    r    = s2_norm_q[1];
    s    = s2_norm_q[0];
    inc  = g && (r || s || mant[0]);
    mr   = {1'b0, mant} + (FRACW+2)'(inc);
    ex   = s2_exp_q;
    fo   = mr[FRACW-1:0];
    if (mr[FRACW+1]) begin
      ex = ex + EW1'(1);
      fo = mr[FRACW:1];
    end else if (ex == '0 && mr[FRACW]) begin
      ex = EW1'(1);                       // subnormal rounded up to min normal
    end
    nx = g || r || s;
    of = ex >= {1'b0, EONES};
    if (s2_spec_q) begin
      s3_res_d = s2_sres_q;
      s3_flg_d = {s2_nv_q, 3'b000};
    end else if (s2_zero_q) begin
      s3_res_d = {s2_zs_q, {(W-1){1'b0}}};
      s3_flg_d = 4'b0000;
    end else if (of) begin
      s3_res_d = {s2_sgn_q, EONES, FZERO};
      s3_flg_d = 4'b0101;
    end else begin
      s3_res_d = {s2_sgn_q, ex[EXPW-1:0], fo};
      s3_flg_d = {2'b00, (ex == '0) && nx, nx};
    end
  end

  logic [W-1:0] s3_res_q;
  logic [3:0]   s3_flg_q;

  // S3 register: the visible result, held while the consumer stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_q     <= 1'b0;
      s3_res_q <= '0;
      s3_flg_q <= '0;
    end else if (adv3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        s3_res_q <= s3_res_d;
        s3_flg_q <= s3_flg_d;
      end
    end
  end

  assign outValid = v3_q;
  assign result   = s3_res_q;
  assign flags    = s3_flg_q;
endmodule

// File: tb/tb_fpu_add_sub_pipe.sv
// Bench for fpu_add_sub_pipe (half precision): directed cases, backpressure
// stream, randomized traffic against an exact-arithmetic reference, and reset.
module tb_fpu_add_sub_pipe;
  logic        clock, reset, inValid, inReady, sub, outValid, outReady;
  logic [15:0] opA, opB, result;
  logic [3:0]  flags;

  fpu_add_sub_pipe #(.EXPW(5), .FRACW(10)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .opA(opA), .opB(opB), .sub(sub), .outValid(outValid), .outReady(outReady),
    .result(result), .flags(flags));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0, n_pass = 0, n_out = 0;
  bit sb_en = 0;
  logic [19:0] exp_q[$];
  logic [15:0] specials [6] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'h7D00, 16'h0000, 16'h8000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%h want=%h", tag, got, want);
  endtask

  // Exact reference: operands as integers in units of 2^-24, sum, then round RNE.
  function automatic logic [19:0] ref_fp(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic sa, sb, an, bn, ai, bi, rs, nx, up, uf;
    int ea, eb, e;
    longint va, vb, sm, m, ulp, q, rem, half;
    logic [4:0] eo;
    sa = a[15]; sb = b[15] ^ s;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    an = (ea == 31) && (a[9:0] != 0); bn = (eb == 31) && (b[9:0] != 0);
    ai = (ea == 31) && (a[9:0] == 0); bi = (eb == 31) && (b[9:0] == 0);
    if (an || bn) return {((an && !a[9]) || (bn && !b[9])), 3'b000, 16'h7E00};
    if (ai && bi && sa != sb) return {4'b1000, 16'h7E00};
    if (ai) return {4'b0000, sa, 5'h1F, 10'h000};
    if (bi) return {4'b0000, sb, 5'h1F, 10'h000};
    va = (ea != 0 ? 1024 : 0) + longint'(a[9:0]);
    vb = (eb != 0 ? 1024 : 0) + longint'(b[9:0]);
    va = va << ((ea == 0 ? 1 : ea) - 1);
    vb = vb << ((eb == 0 ? 1 : eb) - 1);
    sm = (sa ? -va : va) + (sb ? -vb : vb);
    if (sm == 0) return {4'b0000, sa && sb, 15'h0000};
    rs = sm < 0;
    m  = rs ? -sm : sm;
    e  = 1;
    while (m >= (longint'(1) << (e + 10))) e++;
    ulp  = longint'(1) << (e - 1);
    q    = m >> (e - 1);
    rem  = m - q * ulp;
    half = ulp / 2;
    nx   = rem != 0;
    up   = nx && (rem > half || (rem == half && q[0]));
    if (up) q++;
    if (q == 2048) begin q = 1024; e++; end
    if (e >= 31) return {4'b0101, rs, 5'h1F, 10'h000};
    eo = (q < 1024) ? 5'd0 : e[4:0];
    uf = (eo == 0) && nx;
    return {2'b00, uf, nx, rs, eo, q[9:0]};
  endfunction

  function automatic logic [15:0] rnd_fp(input logic [15:0] near);
    logic [15:0] v;
    int e;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v = specials[$urandom_range(0, 5)];
      1, 2, 3: begin
        e = int'(near[14:10]) + int'($urandom_range(0, 2)) - 1;
        if (e < 0) e = 0;
        if (e > 30) e = 30;
        v[14:10] = e[4:0];
      end
      4: v[14:10] = 5'd0;
      default: ;
    endcase
    return v;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clock) begin
    logic [19:0] e;
    if (sb_en && !reset) begin
      if (outValid && outReady) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("stream_res", result, e[15:0]);
          chk("stream_flg", flags, e[19:16]);
        end
      end
      if (inValid && inReady) exp_q.push_back(ref_fp(opA, opB, sub));
    end
  end

  // One isolated operation with outReady high; checks latency, result and flags.
  task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [15:0] er, input logic [3:0] ef);
    int lat;
    inValid = 1'b1; opA = a; opB = b; sub = s; outReady = 1'b1;
    @(posedge clock); #1;
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 10) begin @(posedge clock); #1; lat++; end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flg"}, flags, ef);
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] sa_v [6], sb_v [6];
    logic        ss_v [6];
    int issued;
    bit acc;
    reset = 1'b1; inValid = 1'b0; opA = '0; opB = '0; sub = 1'b0; outReady = 1'b0;
    #3;
    chk("rst_outValid", outValid, 0);
    chk("rst_inReady", inReady, 1);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    inValid = 1'b1; opA = 16'h3C00; opB = 16'h3C00;
    @(posedge clock); @(posedge clock); #1;
    chk("rst_hold_outValid", outValid, 0);
    inValid = 1'b0;
    @(negedge clock); reset = 1'b0;

    run1("one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
    run1("ovf",          16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101);
    run1("inf_m_inf",    16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 4'b1000);
    run1("tie_even",     16'h3C00, 16'h1000, 1'b0, 16'h3C00, 4'b0001);
    run1("tie_up",       16'h3C01, 16'h1000, 1'b0, 16'h3C02, 4'b0001);
    run1("x_m_x",        16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
    run1("sub_add",      16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000);
    run1("norm_to_sub",  16'h0400, 16'h0001, 1'b1, 16'h03FF, 4'b0000);
    run1("sub_m_zero",   16'h0001, 16'h0000, 1'b1, 16'h0001, 4'b0000);
    run1("nz_p_nz",      16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
    run1("nz_m_pz",      16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000);
    run1("snan",         16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 4'b1000);
    run1("qnan",         16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 4'b0000);
    run1("one_m_inf",    16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 4'b0000);

    // Backpressure stream: 6 ops, consumer stalled for the first 5 cycles.
    for (int i = 0; i < 6; i++) begin
      sa_v[i] = rnd_fp(16'($urandom));
      sb_v[i] = rnd_fp(sa_v[i]);
      ss_v[i] = 1'($urandom);
    end
    sb_en = 1; n_out = 0; outReady = 1'b0; issued = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 5) begin
        chk("bp_accepts", issued, 3);
        chk("bp_inReady", inReady, 0);
        outReady = 1'b1;
      end
      if (issued < 6) begin
        inValid = 1'b1; opA = sa_v[issued]; opB = sb_v[issued]; sub = ss_v[issued];
      end else inValid = 1'b0;
      @(negedge clock); acc = inValid && inReady;
      @(posedge clock); #1;
      if (acc) issued++;
    end
    chk("bp_count", n_out, 6);
    chk("bp_empty", exp_q.size(), 0);

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      inValid  = ($urandom_range(0, 9) < 7);
      opA      = rnd_fp(16'($urandom));
      opB      = rnd_fp(opA);
      sub      = 1'($urandom);
      outReady = ($urandom_range(0, 9) < 7);
      @(posedge clock); #1;
    end
    inValid = 1'b0; outReady = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin @(posedge clock); #1; end
    chk("rnd_drained", exp_q.size(), 0);
    sb_en = 0;

    // Reset with three operations in flight.
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inValid = 1'b1; opA = 16'h4000 + 16'(k); opB = 16'h3C00; sub = 1'b0;
      @(posedge clock); #1;
    end
    inValid = 1'b0;
    chk("mid_pre_outValid", outValid, 1);
    reset = 1'b1; #1;
    chk("mid_outValid", outValid, 0);
    chk("mid_inReady", inReady, 1);
    chk("mid_result", result, 0);
    chk("mid_flags", flags, 0);
    @(posedge clock); #1;
    @(negedge clock); reset = 1'b0;
    chk("post_outValid", outValid, 0);
    run1("post_rst", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
